data_serializer: RTL and testbench
==================================

DATA_SERIALIZER -- requirements
Module: data_serializer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: Clock input 1, rising-edge clock; Reset input 1, asynchronous, active-low (0 = reset).
REQ-002 SHALL have Start input 1: request to serialize one word; sampled only in IDLE.
REQ-003 SHALL have Din input 32: word to write; captured when Start is accepted.
REQ-004 SHALL have BaseAddr input 32: byte address of the first byte; captured when Start is accepted.
REQ-005 SHALL have NumBytes input 2: byte count minus 1 (00=1 … 11=4 bytes); captured when Start is accepted.
REQ-006 SHALL have Order input 1: 0 = LSB first, 1 = MSB first; captured when Start is accepted.
REQ-007 SHALL have Ready input 1: the memory side accepts the current byte this cycle.
REQ-008 SHALL have ByteOut output 8: current byte to memory.
REQ-009 SHALL have Address output 32: byte address for ByteOut.
REQ-010 SHALL have Valid output 1: ByteOut and Address are valid.
REQ-011 SHALL have Busy output 1: a transfer is in progress (SEND or DONE).
REQ-012 SHALL have Done output 1: one-cycle pulse after the last byte is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, SEND and DONE; all outputs registered.
REQ-014 In IDLE with Start=1 at a rising edge: SHALL capture inputs, go to SEND, and assert Valid on the next cycle (1-cycle start latency).
REQ-015 In IDLE with Start=0: SHALL stay in IDLE with Valid=0.
REQ-016 Byte selection: for N=NumBytes+1, only Din[8N-1:0] is transferred.
REQ-017 Byte order, Order=0: emit Din[7:0] first, then [15:8], and so on up to byte N-1.
REQ-018 Byte order, Order=1: emit byte N-1 first, down to Din[7:0].
REQ-019 Address SHALL equal BaseAddr for the first byte and increment by 1 per accepted byte, regardless of Order.
REQ-020 Address wraps 32'hFFFFFFFF -> 32'h00000000 with no flag.
REQ-021 Transfer handshake: a byte transfers on a rising edge where Valid=1 and Ready=1.
REQ-022 While Valid=1 and Ready=0: ByteOut, Address and Valid SHALL hold stable, with no timeout.
REQ-023 On transfer of a non-last byte: the next byte and address SHALL appear on the next cycle with Valid held at 1 (back-to-back, one byte per cycle when Ready=1).
REQ-024 On transfer of the last byte: SHALL go to DONE, with Valid=0 and Done=1 for exactly one cycle.
REQ-025 DONE SHALL return to IDLE on the next edge; Start is ignored in DONE.
REQ-026 Busy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-027 Start while Busy=1 SHALL be ignored; the captured word and parameters are not disturbed by input changes during a transfer.
REQ-028 Ready asserted while Valid=0 SHALL have no effect.
REQ-029 The minimum transfer time is N+1 cycles from the Start edge to the Done pulse.

Reset
REQ-030 Reset=0 SHALL force IDLE immediately (asynchronously): ByteOut=8'h00, Address=32'h0, Valid=0, Busy=0, Done=0, internal shift and count registers cleared.
REQ-031 Reset mid-transfer SHALL abort the transfer; remaining bytes are dropped, and no Done is issued.
REQ-032 After Reset deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Verification
REQ-033 Scenario: Din=32'hA1B2C3D4, BaseAddr=32'h100, NumBytes=11, Order=0, Ready=1 -> bytes D4,C3,B2,A1 at 100..103 on consecutive cycles, then Done pulse.
REQ-034 Scenario: same word, Order=1, NumBytes=01 -> bytes C3 then D4 at 100, 101, then Done.
REQ-035 Scenario: NumBytes=00, Din=32'h000000FF, Ready held 0 for 3 cycles then 1 -> FF and the address held stable for 4 Valid cycles; a single transfer; Done.
REQ-036 Scenario: BaseAddr=32'hFFFFFFFE, 4 bytes -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-037 Scenario: Start pulsed again while in SEND with a different Din -> ignored; the original bytes complete unchanged.
REQ-038 Scenario: Reset=0 after the 2nd byte of a 4-byte transfer -> outputs immediately at reset values, no Done; a new Start afterwards completes correctly.

Source files
------------

// File: rtl/data_serializer_if.sv
// data_serializer_if: word request, byte/address stream and status between a
// producer (master) and the serializer (slave).
interface data_serializer_if;
    logic        start;
    logic [31:0] din;
    logic [31:0] base_addr;
    logic [1:0]  num_bytes;
    logic        order;
    logic        ready;
    logic [7:0]  byte_out;
    logic [31:0] address;
    logic        valid;
    logic        busy;
    logic        done;
    modport master (
        output start, din, base_addr, num_bytes, order, ready,
        input  byte_out, address, valid, busy, done
    );
    modport slave (
        input  start, din, base_addr, num_bytes, order, ready,
        output byte_out, address, valid, busy, done
    );
endinterface

// File: rtl/data_serializer.sv
// data_serializer: splits a 1-4 byte word into a byte stream with incrementing
// addresses under a valid/ready handshake; Done pulses after the last byte.
module data_serializer (
    input  logic             clk,
    input  logic             rst_n,
    data_serializer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2;
    logic [1:0]  state;
    logic [31:0] seq;
    logic [31:0] shift;
    logic [1:0]  cnt;
    logic [7:0]  byte_q;
    logic [31:0] addr_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;
    // Reorder the word at capture so bytes always leave from the low end.
    for (genvar i = 0; i < 4; i++) begin : g_seq
        logic [1:0] idx;
        assign idx = bus.order ? bus.num_bytes - 2'(i) : 2'(i);
        assign seq[8*i +: 8] = bus.din[8*idx +: 8];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift   <= '0;
            cnt     <= '0;
            byte_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    shift   <= {8'h00, seq[31:8]};
                    byte_q  <= seq[7:0];
                    addr_q  <= bus.base_addr;
                    cnt     <= bus.num_bytes;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b1;
                    state   <= SEND;
                end
                SEND: if (bus.ready) begin
                    if (cnt == 2'd0) begin
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        byte_q <= shift[7:0];
                        shift  <= shift >> 8;
                        addr_q <= addr_q + 32'd1;
                        cnt    <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.byte_out = byte_q;
    assign bus.address  = addr_q;
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_data_serializer.sv
// tb_data_serializer: table-driven scenarios plus randomized transfers checked
// against a queue-based byte-order model.
module tb_data_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    data_serializer_if bus ();
    data_serializer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0;
    int n_err = 0;
    typedef struct {
        logic [31:0] din;
        logic [31:0] base;
        logic [1:0]  nb;
        logic        ord;
        int          mode;
        bit          noise;
        logic [31:0] seq;
    } vec_t;
    vec_t tbl[6];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // Emission order as a list of bytes; packed with the first byte lowest.
    function automatic logic [31:0] model_seq(input logic [31:0] din, input logic [1:0] nb, input logic ord);
        logic [7:0] q[$];
        logic [31:0] r = '0;
        for (int i = 0; i <= int'(nb); i++) begin
            if (ord) q.push_front(din[8*i +: 8]);
            else q.push_back(din[8*i +: 8]);
        end
        for (int i = 0; i < q.size(); i++) r[8*i +: 8] = q[i];
        return r;
    endfunction
    // mode: 0 ready always, 1 random ready, 2 ready low for 3 cycles then high
    task automatic xfer(input logic [31:0] din, input logic [31:0] base, input logic [1:0] nb,
                        input logic ord, input logic [31:0] seq, input int mode, input bit noise);
        int k = 0;
        int cyc = 0;
        logic rdy;
        bus.din = din; bus.base_addr = base; bus.num_bytes = nb; bus.order = ord;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (k <= int'(nb) && cyc < 64) begin
            chk("valid", 32'(bus.valid), 32'd1);
            chk("busy", 32'(bus.busy), 32'd1);
            chk("done_early", 32'(bus.done), 32'd0);
            chk("byte", 32'(bus.byte_out), 32'(seq[8*k +: 8]));
            chk("addr", bus.address, base + 32'(k));
            rdy = (mode == 0) ? 1'b1 : (mode == 2) ? (cyc >= 3) : 1'($urandom_range(0, 1));
            bus.ready = rdy;
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.din = $urandom;
                bus.base_addr = $urandom;
                bus.num_bytes = 2'($urandom_range(0, 3));
                bus.order = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        chk("byte_count", 32'(k), 32'(nb) + 32'd1);
        if (mode == 0) chk("min_latency", 32'(cyc), 32'(nb) + 32'd1);
        bus.start = 1'b0;
        bus.ready = 1'($urandom_range(0, 1));
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("valid_at_done", 32'(bus.valid), 32'd0);
        chk("busy_at_done", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("done_clear", 32'(bus.done), 32'd0);
        chk("busy_clear", 32'(bus.busy), 32'd0);
        chk("valid_idle", 32'(bus.valid), 32'd0);
    endtask
    initial begin
        bus.start = 1'b0; bus.din = '0; bus.base_addr = '0; bus.num_bytes = '0;
        bus.order = 1'b0; bus.ready = 1'b0;
        tbl[0] = '{32'hA1B2C3D4, 32'h00000100, 2'd3, 1'b0, 0, 1'b0, 32'hA1B2C3D4};
        tbl[1] = '{32'hA1B2C3D4, 32'h00000100, 2'd1, 1'b1, 0, 1'b0, 32'h0000D4C3};
        tbl[2] = '{32'h000000FF, 32'h00000040, 2'd0, 1'b0, 2, 1'b0, 32'h000000FF};
        tbl[3] = '{32'hA1B2C3D4, 32'hFFFFFFFE, 2'd3, 1'b0, 0, 1'b0, 32'hA1B2C3D4};
        tbl[4] = '{32'hA1B2C3D4, 32'h00000200, 2'd3, 1'b1, 1, 1'b1, 32'hD4C3B2A1};
        tbl[5] = '{32'h11223344, 32'h00000010, 2'd2, 1'b1, 1, 1'b1, 32'h00443322};
        #7;
        chk("rst_byte", 32'(bus.byte_out), 32'd0);
        chk("rst_addr", bus.address, 32'd0);
        chk("rst_valid", 32'(bus.valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_valid", 32'(bus.valid), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end
        for (int i = 0; i < 6; i++)
            xfer(tbl[i].din, tbl[i].base, tbl[i].nb, tbl[i].ord, tbl[i].seq, tbl[i].mode, tbl[i].noise);
        // Abort after the second byte of a 4-byte transfer.
        bus.din = 32'hCAFEBABE; bus.base_addr = 32'h300; bus.num_bytes = 2'd3; bus.order = 1'b0;
        bus.ready = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_abort_byte", 32'(bus.byte_out), 32'h000000FE);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_byte", 32'(bus.byte_out), 32'd0);
        chk("abort_addr", bus.address, 32'd0);
        chk("abort_valid", 32'(bus.valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(bus.done), 32'd0);
            chk("abort_no_valid", 32'(bus.valid), 32'd0);
        end
        xfer(32'h55667788, 32'h400, 2'd3, 1'b1, model_seq(32'h55667788, 2'd3, 1'b1), 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d, b;
            logic [1:0] nb;
            logic ord;
            d = $urandom; b = (i % 4 == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 2)) : $urandom;
            nb = 2'($urandom_range(0, 3)); ord = 1'($urandom_range(0, 1));
            xfer(d, b, nb, ord, model_seq(d, nb, ord), i % 3, 1'(i % 2));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
